spi_master_cs: RTL
==================

SPI_MASTER_CS -- requirements
Module: spi_master_cs

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per word (4..32).
REQ-002 SHALL have parameter NUM_CS, default 1, number of chip selects (1..8).
REQ-003 SHALL have parameter CLKS_PER_HALF_BIT, default 2, clk cycles per SPCK half period (>=2); SPCK = clk/(2*CLKS_PER_HALF_BIT).
REQ-004 SHALL have parameter CS_SETUP_CLKS, default 2, clk cycles from CS_n fall to first SPCK edge (>=1).
REQ-005 SHALL have parameter CS_HOLD_CLKS, default 2, clk cycles from last SPCK edge to CS_n rise (>=1).
REQ-006 Ports: clk  in  1  system clock; one clock domain; reset is asynchronous and active-high.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 i_SPI_Mode  in  2  {CPOL,CPHA}, sampled on transaction accept from IDLE.
REQ-009 i_CS_Sel  in  max(1,clog2(NUM_CS))  target slave, sampled with i_SPI_Mode.
REQ-010 i_TX_Data  in  DATA_WIDTH  word to send, MSB first; i_TX_Valid  in  1  word offered; i_TX_Last  in  1  final word of transaction; o_TX_Ready  out  1  word accepted when Valid&Ready.
REQ-011 o_RX_Data  out  DATA_WIDTH  received word; o_RX_Valid  out  1  one-cycle pulse per received word; o_Busy  out  1  high in any state but IDLE.
REQ-012 o_SPCK  out  1; o_MOSI  out  1; i_MISO  in  1; o_CS_n  out  NUM_CS  active-low selects.

Function
REQ-013 FSM states: IDLE, SETUP, XFER, WAIT, HOLD.
REQ-014 IDLE: o_TX_Ready=1; on accept latch data, Last, mode, select; next cycle o_CS_n[sel]=0, o_SPCK=latched CPOL, go SETUP.
REQ-015 SETUP: count CS_SETUP_CLKS cycles, then XFER.
REQ-016 XFER: generate 2*DATA_WIDTH SPCK edges, one per CLKS_PER_HALF_BIT cycles; o_SPCK returns to CPOL after last edge.
REQ-017 CPHA=0: MSB on o_MOSI by CS_n fall (or WAIT exit), shift on trailing edges, sample i_MISO on leading edges.
REQ-018 CPHA=1: shift on leading edges (MSB on first), sample on trailing edges.
REQ-019 o_RX_Valid pulses one cycle, with o_RX_Data updated, the cycle after the final sample edge.
REQ-020 After last edge: latched Last=1 -> HOLD; Last=0 -> WAIT.
REQ-021 WAIT: CS_n held low, SPCK at CPOL, o_TX_Ready=1; on accept go XFER next cycle; mode/select NOT re-sampled.
REQ-022 HOLD: count CS_HOLD_CLKS cycles, drive all o_CS_n high, go IDLE; IDLE lasts >=1 cycle (min CS_n high time).
REQ-023 o_TX_Ready SHALL be 0 in SETUP, XFER, HOLD; i_TX_Valid there is ignored, not queued.
REQ-024 i_CS_Sel >= NUM_CS: no CS_n asserted, transfer still clocked and received.
REQ-025 Only one o_CS_n bit SHALL be low at any time.
REQ-026 Counters SHALL wrap to zero at terminal count, never overflow their width.

Reset
REQ-027 rst asserted: immediately, in any state, o_CS_n all 1, o_SPCK=0, o_MOSI=0, o_TX_Ready=0, o_RX_Valid=0, o_RX_Data=0, o_Busy=0, latched mode 0, FSM IDLE.
REQ-028 o_TX_Ready SHALL rise on the first clk edge after rst release.
REQ-029 Reset mid-transaction SHALL abort without emitting o_RX_Valid.

Configuration
REQ-030 Macro SPI_LSB_FIRST_EN defined: add port i_LSB_First (in, 1), sampled with i_SPI_Mode; 1 sends and assembles LSB first.
REQ-031 Macro absent: no i_LSB_First port; MSB first always.

Verification
REQ-032 Mode 0, DATA_WIDTH=8, send 0xA5 Last=1, MISO loopback -> MOSI bits 1,0,1,0,0,1,0,1; o_RX_Data=0xA5; one o_RX_Valid pulse.
REQ-033 Mode 3, 3-word burst 0x12,0x34,0x56 (Last on third) -> CS_n low throughout, 24 SPCK edge pairs, idle-high SPCK, 3 RX pulses.
REQ-034 CLKS_PER_HALF_BIT=2, CS_SETUP_CLKS=3, CS_HOLD_CLKS=2, one word -> CS_n low 3+32+2=37 cycles, then high >=1 cycle.
REQ-035 NUM_CS=4, i_CS_Sel=2 then 5 -> o_CS_n=4'b1011, then 4'b1111 with SPCK still toggling.
REQ-036 rst pulsed mid-XFER -> all outputs at reset values within that cycle; no RX pulse; next transfer correct.
REQ-037 SPI_LSB_FIRST_EN defined, i_LSB_First=1, send 0x01 -> first MOSI bit 1, then seven 0s.

Source files
------------

// File: rtl/spi_master_cs.sv
// SPI master with per-slave chip selects, programmable mode and CS setup/hold.
// Words are streamed through a valid/ready handshake; a transaction keeps CS_n
// low across words until a word marked Last has been shifted.
// Optional build macro: SPI_LSB_FIRST_EN adds i_LSB_First for LSB-first words.
module spi_master_cs #(
   parameter int DATA_WIDTH        = 8,
   parameter int NUM_CS            = 1,
   parameter int CLKS_PER_HALF_BIT = 2,
   parameter int CS_SETUP_CLKS     = 2,
   parameter int CS_HOLD_CLKS      = 2,
   localparam int SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            i_SPI_Mode,
   input  logic [SEL_W-1:0]      i_CS_Sel,
   input  logic [DATA_WIDTH-1:0] i_TX_Data,
   input  logic                  i_TX_Valid,
   input  logic                  i_TX_Last,
   output logic                  o_TX_Ready,
   output logic [DATA_WIDTH-1:0] o_RX_Data,
   output logic                  o_RX_Valid,
   output logic                  o_Busy,
   output logic                  o_SPCK,
   output logic                  o_MOSI,
   input  logic                  i_MISO,
`ifdef SPI_LSB_FIRST_EN
   input  logic                  i_LSB_First,
`endif
   output logic [NUM_CS-1:0]     o_CS_n
);

   localparam int CNT_MAX0 = (CLKS_PER_HALF_BIT > CS_SETUP_CLKS) ? CLKS_PER_HALF_BIT : CS_SETUP_CLKS;
   localparam int CNT_MAX  = (CNT_MAX0 > CS_HOLD_CLKS) ? CNT_MAX0 : CS_HOLD_CLKS;
   localparam int CNT_W    = $clog2(CNT_MAX);
   localparam int EDGE_W   = $clog2(2 * DATA_WIDTH);

   localparam logic [CNT_W-1:0]  HALF_TC   = CNT_W'(CLKS_PER_HALF_BIT - 1);
   localparam logic [CNT_W-1:0]  SETUP_TC  = CNT_W'(CS_SETUP_CLKS - 1);
   localparam logic [CNT_W-1:0]  HOLD_TC   = CNT_W'(CS_HOLD_CLKS - 1);
   localparam logic [EDGE_W-1:0] EDGE_TC   = EDGE_W'(2 * DATA_WIDTH - 1);
   localparam logic [EDGE_W-1:0] LEAD_LAST = EDGE_W'(2 * DATA_WIDTH - 2);

   typedef enum logic [2:0] {IDLE, SETUP, XFER, WAIT, HOLD} state_t;

   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [EDGE_W-1:0]     r_edge;
   logic [DATA_WIDTH-1:0] r_tx;
   logic [DATA_WIDTH-1:0] r_rx;
   logic                  r_last;
   logic                  r_cpol;
   logic                  r_cpha;
   logic                  r_SPCK;
   logic                  r_MOSI;
   logic [NUM_CS-1:0]     r_CS_n;
   logic                  r_TX_Ready;
   logic                  r_RX_Valid;
   logic [DATA_WIDTH-1:0] r_RX_Data;
   logic                  r_Busy;

   logic                  w_lsb;       // bit order of the word in flight
   logic                  w_lsb_in;    // bit order applied to the word being accepted
   logic                  w_cpha_in;   // phase applied to the word being accepted
   logic                  w_accept;
   logic                  w_lead;      // current SPCK edge is a leading edge
   logic [EDGE_W-1:0]     w_samp_tc;   // index of the final sampling edge

`ifdef SPI_LSB_FIRST_EN
   logic r_lsb;
   assign w_lsb    = r_lsb;
   assign w_lsb_in = (r_state == IDLE) ? i_LSB_First : r_lsb;
`else
   assign w_lsb    = 1'b0;
   assign w_lsb_in = 1'b0;
`endif

   assign w_cpha_in = (r_state == IDLE) ? i_SPI_Mode[0] : r_cpha;
   assign w_accept  = i_TX_Valid & r_TX_Ready;
   assign w_lead    = ~r_edge[0];
   assign w_samp_tc = r_cpha ? EDGE_TC : LEAD_LAST;

   // Out-of-range selects leave every chip select deasserted.
   function automatic logic [NUM_CS-1:0] cs_decode(input logic [SEL_W-1:0] sel);
      logic [NUM_CS-1:0] cs;
      cs = '1;
      for (int i = 0; i < NUM_CS; i++)
         if (sel == SEL_W'(i)) cs[i] = 1'b0;
      return cs;
   endfunction

   function automatic logic first_bit(input logic [DATA_WIDTH-1:0] d, input logic lsb);
      return lsb ? d[0] : d[DATA_WIDTH-1];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] d, input logic lsb);
      return lsb ? {1'b0, d[DATA_WIDTH-1:1]} : {d[DATA_WIDTH-2:0], 1'b0};
   endfunction

   function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] d, input logic b,
                                                      input logic lsb);
      return lsb ? {b, d[DATA_WIDTH-1:1]} : {d[DATA_WIDTH-2:0], b};
   endfunction

   // Transaction FSM: handshake, CS framing, SPCK edge generation and shifting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_edge     <= '0;
         r_tx       <= '0;
         r_rx       <= '0;
         r_last     <= 1'b0;
         r_cpol     <= 1'b0;
         r_cpha     <= 1'b0;
         r_SPCK     <= 1'b0;
         r_MOSI     <= 1'b0;
         r_CS_n     <= '1;
         r_TX_Ready <= 1'b0;
         r_RX_Valid <= 1'b0;
         r_RX_Data  <= '0;
         r_Busy     <= 1'b0;
`ifdef SPI_LSB_FIRST_EN
         r_lsb      <= 1'b0;
`endif
      end else begin
         r_RX_Valid <= 1'b0;

         // Word load shared by IDLE and WAIT: CPHA=0 presents the first bit now.
         if (w_accept) begin
            r_last     <= i_TX_Last;
            r_TX_Ready <= 1'b0;
            r_cnt      <= '0;
            if (w_cpha_in) begin
               r_tx <= i_TX_Data;
            end else begin
               r_MOSI <= first_bit(i_TX_Data, w_lsb_in);
               r_tx   <= shift_out(i_TX_Data, w_lsb_in);
            end
         end

         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_cpol  <= i_SPI_Mode[1];
                  r_cpha  <= i_SPI_Mode[0];
                  r_SPCK  <= i_SPI_Mode[1];
                  r_CS_n  <= cs_decode(i_CS_Sel);
                  r_edge  <= '0;
                  r_Busy  <= 1'b1;
                  r_state <= SETUP;
`ifdef SPI_LSB_FIRST_EN
                  r_lsb   <= i_LSB_First;
`endif
               end else begin
                  r_TX_Ready <= 1'b1;
               end
            end
            SETUP: begin
               if (r_cnt == SETUP_TC) begin
                  r_cnt   <= '0;
                  r_state <= XFER;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            XFER: begin
               if (r_cnt == HALF_TC) begin
                  r_cnt  <= '0;
                  r_SPCK <= ~r_SPCK;
                  if (w_lead == r_cpha) begin
                     r_MOSI <= first_bit(r_tx, w_lsb);
                     r_tx   <= shift_out(r_tx, w_lsb);
                  end else begin
                     r_rx <= shift_in(r_rx, i_MISO, w_lsb);
                  end
                  if (r_edge == w_samp_tc) begin
                     r_RX_Valid <= 1'b1;
                     r_RX_Data  <= shift_in(r_rx, i_MISO, w_lsb);
                  end
                  if (r_edge == EDGE_TC) begin
                     r_edge <= '0;
                     if (r_last) begin
                        r_state <= HOLD;
                     end else begin
                        r_TX_Ready <= 1'b1;
                        r_state    <= WAIT;
                     end
                  end else begin
                     r_edge <= r_edge + 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            WAIT: begin
               r_SPCK <= r_cpol;
               if (w_accept) r_state <= XFER;
            end
            HOLD: begin
               if (r_cnt == HOLD_TC) begin
                  r_cnt      <= '0;
                  r_CS_n     <= '1;
                  r_Busy     <= 1'b0;
                  r_TX_Ready <= 1'b1;
                  r_state    <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_TX_Ready = r_TX_Ready;
   assign o_RX_Data  = r_RX_Data;
   assign o_RX_Valid = r_RX_Valid;
   assign o_Busy     = r_Busy;
   assign o_SPCK     = r_SPCK;
   assign o_MOSI     = r_MOSI;
   assign o_CS_n     = r_CS_n;

endmodule
